// File: rtl/eeprom_test.sv
// eeprom_test: I2C 24Cxx write/read-back self-test master.
// LED: [0] busy, [1] write ok, [2] pass, [3] error.
module eeprom_test #(
  parameter int         CLK_DIV   = 500,
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter logic [7:0] WORD_ADDR = 8'h00,
  parameter logic [7:0] TEST_DATA = 8'hA5,
  parameter int         WR_WAIT   = 500000
) (
  input  logic       CLK_50M,
  input  logic       RSTn,
  output logic [3:0] LED,
  output logic       SCL,
  inout  wire        SDA
);
  localparam int QLEN = CLK_DIV / 4;
  localparam int QW   = (QLEN > 1) ? $clog2(QLEN) : 1;
  localparam int WW   = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_STOP, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t        st_q, st_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    q_q, q_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    idx_q, idx_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic          samp_q, samp_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;
  logic [3:0]    led_q, led_d;
  logic          tick, rd_byte;

  assign SCL = scl_q;
  assign LED = led_q;
  assign SDA = oe_q ? 1'b0 : 1'bz;

  // Byte 3 of the read phase is the data byte: all ones keeps SDA released.
  function automatic logic [7:0] byte_sel(input logic rd,
                                          input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = {DEV_ADDR, 1'b0};
      2'd1:    b = WORD_ADDR;
      2'd2:    b = rd ? {DEV_ADDR, 1'b1} : TEST_DATA;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  always_comb begin
    st_d    = st_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    err_d   = err_q;
    samp_d  = samp_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wcnt_d  = wcnt_q;
    scl_d   = scl_q;
    oe_d    = oe_q;
    led_d   = led_q;
    tick    = (qcnt_q == QW'(QLEN - 1));
    rd_byte = rd_q & (idx_q == 2'd3);
    qcnt_d  = tick ? '0 : qcnt_q + 1'b1;
    q_d     = tick ? q_q + 2'd1 : q_q;

    if (tick) begin
      unique case (q_q)
        2'd0: begin
          if (st_q == S_START) oe_d = 1'b0;
          if (st_q == S_STOP)  oe_d = 1'b1;
          if (st_q == S_BIT)   oe_d = (bit_q != 4'd8) & ~tx_q[7];
        end
        2'd1: begin
          if (st_q inside {S_START, S_BIT, S_STOP}) scl_d = 1'b1;
        end
        2'd2: begin
          if (st_q == S_START) oe_d = 1'b1;
          if (st_q == S_STOP)  oe_d = 1'b0;
          if (SDA == 1'b0) samp_d = 1'b0;
          else             samp_d = 1'b1;
        end
        default: begin
          unique case (st_q)
            S_IDLE: begin
              led_d[0] = 1'b1;
              st_d     = S_START;
              rd_d     = 1'b0;
              idx_d    = 2'd0;
              scl_d    = 1'b0;
            end
            S_START: begin
              tx_d  = byte_sel(rd_q, idx_q);
              bit_d = 4'd0;
              st_d  = S_BIT;
              scl_d = 1'b0;
            end
            S_BIT: begin
              scl_d = 1'b0;
              if (bit_q != 4'd8) begin
                bit_d = bit_q + 4'd1;
                tx_d  = {tx_q[6:0], 1'b1};
                if (rd_byte) rx_d = {rx_q[6:0], samp_q};
              end else begin
                bit_d = 4'd0;
                if (!rd_byte && samp_q) begin
                  err_d = 1'b1;
                  st_d  = S_STOP;
                end else if (rd_byte || (!rd_q && idx_q == 2'd2)) begin
                  st_d = S_STOP;
                end else if (rd_q && idx_q == 2'd1) begin
                  idx_d = 2'd2;
                  st_d  = S_START;
                end else begin
                  idx_d = idx_q + 2'd1;
                  tx_d  = byte_sel(rd_q, idx_q + 2'd1);
                end
              end
            end
            S_STOP: begin
              if (err_q) begin
                led_d[3] = 1'b1;
                led_d[0] = 1'b0;
                st_d     = S_DONE;
              end else if (!rd_q) begin
                led_d[1] = 1'b1;
                wcnt_d   = '0;
                st_d     = S_WAIT;
              end else begin
                st_d = S_CHECK;
              end
            end
            default: ;
          endcase
        end
      endcase
    end

    // The write-cycle wait is cycle-exact; the read START re-phases the bit clock.
    if (st_q == S_WAIT) begin
      if (wcnt_q == WW'(WR_WAIT - 1)) begin
        st_d   = S_START;
        rd_d   = 1'b1;
        idx_d  = 2'd0;
        qcnt_d = '0;
        q_d    = 2'd0;
        scl_d  = 1'b0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    if (st_q == S_CHECK) begin
      led_d[0] = 1'b0;
      if (rx_q == TEST_DATA) led_d[2] = 1'b1;
      else                   led_d[3] = 1'b1;
      st_d = S_DONE;
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      st_q   <= S_IDLE;
      qcnt_q <= '0;
      q_q    <= 2'd0;
      bit_q  <= 4'd0;
      idx_q  <= 2'd0;
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
      samp_q <= 1'b1;
      tx_q   <= 8'hFF;
      rx_q   <= 8'h00;
      wcnt_q <= '0;
      scl_q  <= 1'b1;
      oe_q   <= 1'b0;
      led_q  <= 4'b0000;
    end else begin
      st_q   <= st_d;
      qcnt_q <= qcnt_d;
      q_q    <= q_d;
      bit_q  <= bit_d;
      idx_q  <= idx_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
      samp_q <= samp_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      wcnt_q <= wcnt_d;
      scl_q  <= scl_d;
      oe_q   <= oe_d;
      led_q  <= led_d;
    end
  end
endmodule

// File: tb/tb_eeprom_test.sv
// tb_eeprom_test: bus-level slave model, token log and LED checks
// for the eeprom_test self-test master.
module tb_eeprom_test;
  localparam int CLK_DIV = 8;
  localparam int WR_WAIT = 100;
  localparam int T_S = 1000;
  localparam int T_P = 1001;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  wire  [3:0] led;
  wire        scl;
  wire        sda;
  logic       s_low = 1'b0;

  assign sda = s_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  eeprom_test #(.CLK_DIV(CLK_DIV), .WR_WAIT(WR_WAIT)) dut (
    .CLK_50M(clk),
    .RSTn   (rstn),
    .LED    (led),
    .SCL    (scl),
    .SDA    (sda)
  );

  // slave configuration
  logic       sl_present = 1'b0;
  int         sl_nack = -1;
  logic [7:0] sl_rdata = 8'hA5;

  // bus monitor / slave state
  int         cyc = 0;
  logic       pscl = 1'b1, psda = 1'b1;
  int         tok[$];
  int         tok_cyc[$];
  int         bitn = 0, bytn = 0;
  logic [7:0] sh = 8'h00;
  logic       rdm = 1'b0, pend = 1'b0;
  int         last_rise = 0;
  logic       stop_seen = 1'b1;
  int         per_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      s_low = 1'b0; bitn = 0; bytn = 0;
      rdm = 1'b0; pend = 1'b0; stop_seen = 1'b1;
    end else if (scl && pscl && psda && !sda) begin
      tok.push_back(T_S); tok_cyc.push_back(cyc);
      bitn = 0; bytn = 0; rdm = 1'b0; pend = 1'b0;
    end else if (scl && pscl && !psda && sda) begin
      tok.push_back(T_P); tok_cyc.push_back(cyc);
      bitn = 0; rdm = 1'b0; pend = 1'b0; s_low = 1'b0;
      stop_seen = 1'b1;
    end else if (scl && !pscl) begin
      if (!stop_seen && (cyc - last_rise) != CLK_DIV) per_err++;
      last_rise = cyc;
      stop_seen = 1'b0;
      if (bitn < 8) begin
        sh = {sh[6:0], sda};
        bitn++;
      end else if (bitn == 8) begin
        tok.push_back(int'(sh) + (sda ? 256 : 0));
        tok_cyc.push_back(cyc);
        bitn = 9;
      end
    end else if (!scl && pscl) begin
      if (bitn == 8) begin
        if (!rdm) begin
          s_low = sl_present && (bytn != sl_nack);
          if (bytn == 0 && sh[0]) pend = 1'b1;
        end else begin
          s_low = 1'b0;
        end
      end else if (bitn == 9) begin
        bitn = 0; bytn++; s_low = 1'b0;
        if (pend) begin
          rdm = 1'b1; pend = 1'b0;
          s_low = sl_present && !sl_rdata[7];
        end else begin
          rdm = 1'b0;
        end
      end else if (rdm && bitn >= 1 && bitn <= 7) begin
        s_low = !sl_rdata[7 - bitn];
      end
    end
    pscl = scl;
    psda = sda;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       present;
    int         nack;
    logic [7:0] rdata;
    logic [3:0] exp_led;
    int         ntok;
  } vec_t;

  vec_t v[4];
  int   exp_tok[4][12];

  task automatic run_to_done(input int budget, output logic ok,
                             output logic busy_bad);
    ok = 1'b0;
    busy_bad = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (led[0] && led[3:2] != 2'b00) busy_bad = 1'b1;
      if (!led[0] && (led[2] || led[3])) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tok.delete();
    tok_cyc.delete();
    per_err = 0;
  endtask

  initial begin
    logic ok, bb;
    int   rel, n, act;

    v[0] = '{1'b0, -1, 8'hA5, 4'b1000, 3};
    v[1] = '{1'b1, -1, 8'hA5, 4'b0110, 12};
    v[2] = '{1'b1, -1, 8'h5A, 4'b1010, 12};
    v[3] = '{1'b1,  2, 8'hA5, 4'b1000, 5};
    exp_tok[0] = '{T_S, 'h1A0, T_P, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_tok[1] = '{T_S, 'hA0, 'h00, 'hA5, T_P,
                   T_S, 'hA0, 'h00, T_S, 'hA1, 'h1A5, T_P};
    exp_tok[2] = '{T_S, 'hA0, 'h00, 'hA5, T_P,
                   T_S, 'hA0, 'h00, T_S, 'hA1, 'h15A, T_P};
    exp_tok[3] = '{T_S, 'hA0, 'h00, 'h1A5, T_P, 0, 0, 0, 0, 0, 0, 0};

    for (int k = 0; k < 4; k++) begin
      sl_present = v[k].present;
      sl_nack    = v[k].nack;
      sl_rdata   = v[k].rdata;
      apply_reset();
      chk($sformatf("v%0d_rst_led", k), 32'(led), 32'h0);
      chk($sformatf("v%0d_rst_scl", k), 32'(scl), 32'h1);
      chk($sformatf("v%0d_rst_sda", k), 32'(sda), 32'h1);
      rstn = 1'b1;
      rel = cyc;
      run_to_done(4000, ok, bb);
      chk($sformatf("v%0d_done", k), 32'(ok), 32'h1);
      chk($sformatf("v%0d_busy_leds", k), 32'(bb), 32'h0);
      repeat (60) @(negedge clk);
      chk($sformatf("v%0d_led", k), 32'(led), 32'(v[k].exp_led));
      chk($sformatf("v%0d_idle_scl", k), 32'(scl), 32'h1);
      chk($sformatf("v%0d_idle_sda", k), 32'(sda), 32'h1);
      chk($sformatf("v%0d_ntok", k), 32'(tok.size()), 32'(v[k].ntok));
      n = (tok.size() < v[k].ntok) ? tok.size() : v[k].ntok;
      for (int i = 0; i < v[k].ntok; i++) begin
        act = (i < n) ? tok[i] : -1;
        chk($sformatf("v%0d_tok%0d", k, i), 32'(act), 32'(exp_tok[k][i]));
      end
      chk($sformatf("v%0d_scl_period", k), 32'(per_err), 32'h0);
      if (k == 0 && tok.size() > 0) begin
        act = tok_cyc[0] - rel;
        chk("first_start_win", 32'(act >= 10 && act <= 20), 32'h1);
      end
      if (k == 1 && tok.size() > 5) begin
        act = tok_cyc[5] - tok_cyc[4];
        chk("wr_wait_gap", 32'(act >= 100 && act <= 116), 32'h1);
      end
    end

    // reset in the middle of the read data byte, then a clean rerun
    sl_present = 1'b1;
    sl_nack    = -1;
    sl_rdata   = 8'hA5;
    apply_reset();
    rstn = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (tok.size() >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reach_read", 32'(ok), 32'h1);
    repeat (20) @(negedge clk);
    chk("mid_busy", 32'(led), 32'b0011);
    rstn = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_scl", 32'(scl), 32'h1);
    @(negedge clk);
    #1;
    chk("mid_rst_sda", 32'(sda), 32'h1);
    repeat (2) @(negedge clk);
    tok.delete();
    tok_cyc.delete();
    per_err = 0;
    rstn = 1'b1;
    run_to_done(4000, ok, bb);
    chk("rerun_done", 32'(ok), 32'h1);
    chk("rerun_busy_leds", 32'(bb), 32'h0);
    repeat (20) @(negedge clk);
    chk("rerun_led", 32'(led), 32'b0110);
    chk("rerun_ntok", 32'(tok.size()), 32'd12);
    chk("rerun_scl_period", 32'(per_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
